// File: rtl/pcap_axis_pkg.sv
// Shared types and defaults for the pcap AXI-Stream packet path.
package pcap_axis_pkg;

    localparam int DEF_TDATA_WIDTH  = 512;
    localparam int DEF_PKT_MTU_BYTE = 1518;
    localparam int MAX_ID_WIDTH     = 4;

    typedef struct packed {
        logic [DEF_TDATA_WIDTH-1:0]   tdata;
        logic [DEF_TDATA_WIDTH/8-1:0] tkeep;
        logic                         tlast;
        logic [MAX_ID_WIDTH-1:0]      tid;
    } axis_beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer; output comes straight from the head register.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] spare_data;
    logic             spare_valid;
    logic             push;
    logic             pop;
    logic [1:0]       count;
    logic [1:0]       count_next;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign count = {1'b0, out_valid} + {1'b0, spare_valid};

    // Occupancy after this cycle's push/pop, used to register in_ready.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    // Head/spare registers; the spare only fills while the head is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            spare_data  <= '0;
            spare_valid <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            in_ready <= (count_next != 2'd2);
            case ({push, pop})
                2'b10: begin
                    if (!out_valid) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                    end else begin
                        spare_data  <= in_data;
                        spare_valid <= 1'b1;
                    end
                end
                2'b01: begin
                    if (spare_valid) begin
                        out_data    <= spare_data;
                        spare_valid <= 1'b0;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (spare_valid) begin
                        out_data   <= spare_data;
                        spare_data <= in_data;
                    end else begin
                        out_data <= in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic round-robin merge of several AXI-Stream sources onto one output.
module axis_pkt_arbiter
    import pcap_axis_pkg::*;
#(
    parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int NUM_PORTS   = 4,
    parameter int ID_WIDTH    = $clog2(NUM_PORTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                 s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                 s_axis_tready,
    output logic [TDATA_WIDTH-1:0]               m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic                                 m_axis_tlast,
    output logic [ID_WIDTH-1:0]                  m_axis_tid,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 busy,
    output logic [ID_WIDTH-1:0]                  grant
);

    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int BEAT_WIDTH = TDATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH;

    arb_state_e              state;
    arb_state_e              state_next;
    logic [ID_WIDTH-1:0]     grant_next;
    logic [ID_WIDTH-1:0]     last_grant;
    logic                    req_any;
    logic                    skid_in_ready;
    logic                    push;
    logic [TDATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic                    sel_last;
    logic [BEAT_WIDTH-1:0]   skid_in;
    logic [BEAT_WIDTH-1:0]   skid_out;

    // Rotate requests so the port after the last winner sits at bit 0, then pick the lowest set bit.
    function automatic logic [ID_WIDTH-1:0] rr_select(input logic [NUM_PORTS-1:0] req,
                                                      input logic [ID_WIDTH-1:0]  last);
        logic [NUM_PORTS-1:0] rotated;
        logic [ID_WIDTH-1:0]  pick;
        int                   start;
        start   = (int'(last) + 1) % NUM_PORTS;
        rotated = (req >> start) | (req << (NUM_PORTS - start));
        pick    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                pick = ID_WIDTH'((k + start) % NUM_PORTS);
            end
        end
        return pick;
    endfunction

    assign req_any  = |s_axis_tvalid;
    assign busy     = (state == GRANT);
    assign sel_data = s_axis_tdata[int'(grant)*TDATA_WIDTH +: TDATA_WIDTH];
    assign sel_keep = s_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
    assign sel_last = s_axis_tlast[grant];
    assign push     = (state == GRANT) && s_axis_tvalid[grant] && skid_in_ready;
    assign skid_in  = {sel_data, sel_keep, sel_last, grant};

    // Only the granted port sees ready, and only from registered state.
    always_comb begin
        s_axis_tready = '0;
        if (state == GRANT) begin
            s_axis_tready[grant] = skid_in_ready;
        end
    end

    // Arbitrate in IDLE; hold the grant until the tlast beat is accepted.
    always_comb begin
        state_next = state;
        grant_next = grant;
        case (state)
            IDLE: begin
                if (req_any) begin
                    grant_next = rr_select(s_axis_tvalid, last_grant);
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (push && sel_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, grant and fairness pointer registers; port 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (state == IDLE && req_any) begin
                last_grant <= grant_next;
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH (BEAT_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (skid_in),
        .in_valid  (push),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid} = skid_out;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: drivers queue expected beats, a monitor pops and compares.
module tb_axis_pkt_arbiter;

    localparam int W   = 512;
    localparam int KW  = W / 8;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int BW  = W + KW + 1 + IDW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] s_axis_tdata;
    logic [N*KW-1:0] s_axis_tkeep;
    logic [N-1:0]   s_axis_tlast;
    logic [N-1:0]   s_axis_tvalid;
    logic [N-1:0]   s_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tlast;
    logic [IDW-1:0] m_axis_tid;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic           busy;
    logic [IDW-1:0] grant;

    logic [W-1:0]   src_data  [N];
    logic [KW-1:0]  src_keep  [N];
    logic           src_last  [N];
    logic           src_valid [N];

    int             errors = 0;
    int             checks = 0;
    int             cyc    = 0;
    int             occ    = 0;
    bit             bp_en  = 1'b0;
    bit             saw_full = 1'b0;

    logic [BW-1:0]  exp_q[$];
    int             in_cyc_q[$];
    int             out_cyc_q[$];

    for (genvar i = 0; i < N; i++) begin : g_flat
        assign s_axis_tdata[i*W +: W]   = src_data[i];
        assign s_axis_tkeep[i*KW +: KW] = src_keep[i];
        assign s_axis_tlast[i]          = src_last[i];
        assign s_axis_tvalid[i]         = src_valid[i];
    end

    axis_pkt_arbiter #(
        .TDATA_WIDTH (W),
        .NUM_PORTS   (N),
        .ID_WIDTH    (IDW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .grant         (grant)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp input and output handshakes.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [BW-1:0] actual,
                                input logic [BW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [BW-1:0] make_beat(input int p, input int nbeats, input int base,
                                                input int b, input logic [KW-1:0] last_keep,
                                                input bit with_last);
        logic        is_last;
        logic [KW-1:0] keep;
        is_last = with_last && (b == nbeats - 1);
        keep    = is_last ? last_keep : {KW{1'b1}};
        return {W'(base + b), keep, is_last, IDW'(p)};
    endfunction

    task automatic expect_pkt(input int p, input int nbeats, input int base,
                              input logic [KW-1:0] last_keep);
        for (int b = 0; b < nbeats; b++) begin
            exp_q.push_back(make_beat(p, nbeats, base, b, last_keep, 1'b1));
        end
    endtask

    task automatic wait_accept(input int p);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready[p]) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout port %0d: actual=no_ready required=ready", p);
                break;
            end
        end
        in_cyc_q.push_back(cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int p, input int nbeats, input int base,
                                  input logic [KW-1:0] last_keep);
        logic [BW-1:0] beat;
        for (int b = 0; b < nbeats; b++) begin
            beat = make_beat(p, nbeats, base, b, last_keep, 1'b1);
            src_data[p]  = beat[BW-1 -: W];
            src_keep[p]  = beat[IDW+1 +: KW];
            src_last[p]  = beat[IDW];
            src_valid[p] = 1'b1;
            wait_accept(p);
        end
        src_valid[p] = 1'b0;
        src_last[p]  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_output(name, BW'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_valid[i] = 1'b0;
            src_last[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_cyc_q.delete();
        out_cyc_q.delete();
    endtask

    // Monitor: pop the scoreboard on every output handshake and track skid occupancy.
    always @(negedge clk) begin
        logic [BW-1:0] exp_beat;
        int            push_obs;
        int            pop_obs;
        if (m_axis_tvalid && m_axis_tready) begin
            out_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: actual=%0h required=none",
                         {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid});
            end else begin
                exp_beat = exp_q.pop_front();
                check_output("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid},
                             exp_beat);
            end
        end
        if (bp_en && busy) begin
            check_output("bp_ready_p1", BW'(s_axis_tready[1]), BW'(occ < 2));
            if (occ == 2) saw_full = 1'b1;
        end
        push_obs = (|(s_axis_tvalid & s_axis_tready)) ? 1 : 0;
        pop_obs  = (m_axis_tvalid && m_axis_tready) ? 1 : 0;
        if (rst) occ = 0;
        else     occ = occ + push_obs - pop_obs;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_start;
        for (int i = 0; i < N; i++) begin
            src_data[i]  = '0;
            src_keep[i]  = '0;
            src_last[i]  = 1'b0;
            src_valid[i] = 1'b0;
        end

        // Reset values
        reset_dut();
        check_output("rst_tvalid", BW'(m_axis_tvalid), '0);
        check_output("rst_tdata",  BW'(m_axis_tdata),  '0);
        check_output("rst_tkeep",  BW'(m_axis_tkeep),  '0);
        check_output("rst_tlast",  BW'(m_axis_tlast),  '0);
        check_output("rst_tid",    BW'(m_axis_tid),    '0);
        check_output("rst_sready", BW'(s_axis_tready), '0);
        check_output("rst_busy",   BW'(busy),          '0);
        check_output("rst_grant",  BW'(grant),         '0);

        // Single 3-beat packet on port 0
        $display("[TB] single packet");
        reset_dut();
        expect_pkt(0, 3, 'h100, 64'h0000_0000_0000_00FF);
        t_start = cyc;
        apply_stimulus(0, 3, 'h100, 64'h0000_0000_0000_00FF);
        drain("sp_drain");
        check_output("sp_ready_latency", BW'(in_cyc_q[0] - t_start), BW'(1));
        for (int i = 0; i < 3; i++) begin
            check_output("sp_data_latency", BW'(out_cyc_q[i] - in_cyc_q[i]), BW'(1));
        end

        // Round-robin over four continuously requesting ports
        $display("[TB] round robin");
        reset_dut();
        expect_pkt(0, 2, 'h000, '1);
        expect_pkt(1, 2, 'h200, '1);
        expect_pkt(2, 2, 'h400, '1);
        expect_pkt(3, 2, 'h600, '1);
        expect_pkt(0, 2, 'h010, '1);
        expect_pkt(1, 2, 'h210, '1);
        fork
            begin
                apply_stimulus(0, 2, 'h000, '1);
                apply_stimulus(0, 2, 'h010, '1);
            end
            begin
                apply_stimulus(1, 2, 'h200, '1);
                apply_stimulus(1, 2, 'h210, '1);
            end
            apply_stimulus(2, 2, 'h400, '1);
            apply_stimulus(3, 2, 'h600, '1);
        join
        drain("rr_drain");
        check_output("rr_four_pkts_cycles", BW'(out_cyc_q[7] - out_cyc_q[0] + 1), BW'(11));
        check_output("rr_bubble", BW'(out_cyc_q[2] - out_cyc_q[1]), BW'(2));

        // Backpressure with toggling downstream ready
        $display("[TB] backpressure");
        reset_dut();
        bp_en    = 1'b1;
        saw_full = 1'b0;
        expect_pkt(1, 8, 1, '1);
        fork
            apply_stimulus(1, 8, 1, '1);
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    m_axis_tready = ~m_axis_tready;
                end
            end
        join
        m_axis_tready = 1'b1;
        bp_en = 1'b0;
        drain("bp_drain");
        check_output("bp_saw_full", BW'(saw_full), BW'(1));

        // Pointer order: 0 and 3 arrive while 2 is mid-packet
        $display("[TB] pointer order");
        reset_dut();
        expect_pkt(2, 3, 'h500, '1);
        expect_pkt(3, 2, 'h700, '1);
        expect_pkt(0, 2, 'h080, '1);
        fork
            apply_stimulus(2, 3, 'h500, '1);
            begin
                repeat (3) @(posedge clk);
                #1;
                fork
                    apply_stimulus(3, 2, 'h700, '1);
                    apply_stimulus(0, 2, 'h080, '1);
                join
            end
        join
        drain("ptr_drain");

        // Reset in the middle of a 4-beat packet from port 1
        $display("[TB] reset mid-packet");
        reset_dut();
        exp_q.push_back(make_beat(1, 4, 'h300, 0, '1, 1'b1));
        src_data[1]  = W'('h300);
        src_keep[1]  = '1;
        src_last[1]  = 1'b0;
        src_valid[1] = 1'b1;
        wait_accept(1);
        src_data[1] = W'('h301);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("mid_rst_tvalid", BW'(m_axis_tvalid), '0);
        check_output("mid_rst_tdata",  BW'(m_axis_tdata),  '0);
        check_output("mid_rst_sready", BW'(s_axis_tready), '0);
        check_output("mid_rst_busy",   BW'(busy),          '0);
        check_output("mid_rst_grant",  BW'(grant),         '0);
        check_output("mid_rst_scoreboard", BW'(exp_q.size()), '0);
        src_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_pkt(0, 1, 'h0A0, '1);
        expect_pkt(1, 1, 'h3A0, '1);
        fork
            apply_stimulus(0, 1, 'h0A0, '1);
            apply_stimulus(1, 1, 'h3A0, '1);
        join
        drain("mid_rst_drain");

        // Back-to-back single-beat packets from port 1
        $display("[TB] single-beat packets");
        reset_dut();
        for (int k = 0; k < 5; k++) expect_pkt(1, 1, 'h900 + k * 16, 64'h0F);
        for (int k = 0; k < 5; k++) apply_stimulus(1, 1, 'h900 + k * 16, 64'h0F);
        drain("sb_drain");
        for (int i = 0; i < 4; i++) begin
            check_output("sb_spacing", BW'(out_cyc_q[i+1] - out_cyc_q[i]), BW'(2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
